// File: rtl/reg_file_param_pkg.sv
// rtl/reg_file_param_pkg.sv - shared mode encodings and helpers for the register file
package reg_file_param_pkg;

    localparam logic [1:0] REG_MODE_RW  = 2'b00;
    localparam logic [1:0] REG_MODE_RO  = 2'b01;
    localparam logic [1:0] REG_MODE_W1C = 2'b10;

    // Smallest r with 2**r >= value; used to turn the byte stride into a shift.
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_async_rst_n.sv
// rtl/dff_async_rst_n.sv - vector flop with asynchronous active-low reset to a constant
module dff_async_rst_n #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              i_clock,
    input  logic              i_aresetn,
    input  logic [WIDTH-1:0]  i_d,
    output logic [WIDTH-1:0]  o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture next state; reset forces the configured image immediately.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_file_cell.sv
// rtl/reg_file_cell.sv - one register slot with RW / RO / W1C next-state logic
module reg_file_cell
    import reg_file_param_pkg::*;
#(
    parameter int                      DATA_WIDTH = 32,
    parameter logic [1:0]              MODE       = REG_MODE_RW,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                      i_clock,
    input  logic                      i_aresetn,
    input  logic                      i_wr_sel,
    input  logic [DATA_WIDTH-1:0]     i_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   i_wr_strb,
    input  logic [DATA_WIDTH-1:0]     i_hw_data,
    input  logic [DATA_WIDTH-1:0]     i_hw_set,
    output logic [DATA_WIDTH-1:0]     o_q
);

    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] w_byte_mask;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [DATA_WIDTH-1:0] w_rw_next;
    logic [DATA_WIDTH-1:0] w_w1c_next;
    logic [DATA_WIDTH-1:0] w_d;
    logic [DATA_WIDTH-1:0] w_q;

    // Expand byte strobes into a bit mask.
    always_comb begin
        w_byte_mask = '0;
        for (int b = 0; b < NBYTES; b++) begin
            w_byte_mask[b*8 +: 8] = {8{i_wr_strb[b]}};
        end
    end

    assign w_wr_mask  = i_wr_sel ? w_byte_mask : '0;
    assign w_rw_next  = (w_q & ~w_wr_mask) | (i_wr_data & w_wr_mask);
    // Hardware set is OR-ed last so it beats a same-cycle software clear.
    assign w_w1c_next = (w_q & ~(i_wr_data & w_wr_mask)) | i_hw_set;

    // Pick next state by access mode; encoding 11 behaves as RW.
    always_comb begin
        w_d = w_rw_next;
        case (MODE)
            REG_MODE_RO:  w_d = i_hw_data;
            REG_MODE_W1C: w_d = w_w1c_next;
            default:      w_d = w_rw_next;
        endcase
    end

    dff_async_rst_n #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_dff (
        .i_clock   (i_clock),
        .i_aresetn (i_aresetn),
        .i_d       (w_d),
        .o_q       (w_q)
    );

    assign o_q = w_q;

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with byte strobes, RO/W1C slots and irq
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int                                  NUM_REGS    = 8,
    parameter int                                  DATA_WIDTH  = 32,
    parameter int                                  ADDR_WIDTH  = 8,
    parameter logic [2*NUM_REGS-1:0]               REG_MODE    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic                              i_clock,
    input  logic                              i_aresetn,
    input  logic                              i_write_enable,
    input  logic [ADDR_WIDTH-1:0]             i_write_addr,
    input  logic [DATA_WIDTH-1:0]             i_write_data,
    input  logic [DATA_WIDTH/8-1:0]           i_write_strb,
    input  logic                              i_read_enable,
    input  logic [ADDR_WIDTH-1:0]             i_read_addr,
    output logic [DATA_WIDTH-1:0]             o_read_data,
    output logic                              o_read_valid,
    output logic                              o_read_err,
    output logic                              o_write_err,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]    i_hw_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]    i_hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0]    o_reg_data,
    output logic                              o_irq
);

    localparam int                    STRIDE     = DATA_WIDTH / 8;
    localparam int                    OFF_BITS   = log2_ceil(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(STRIDE - 1);
    localparam logic [31:0]           NUM_REGS_U = 32'(NUM_REGS);

    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_wr_bad;
    logic                  w_rd_bad;
    logic [NUM_REGS-1:0]   w_wr_sel;
    logic [NUM_REGS-1:0]   w_irq_bits;
    logic [DATA_WIDTH-1:0] w_cell_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic [DATA_WIDTH-1:0] r_read_data;
    logic                  r_read_valid;
    logic                  r_read_err;
    logic                  r_write_err;

    // Byte address -> register index; misaligned or out-of-range is an error.
    assign w_wr_idx = i_write_addr >> OFF_BITS;
    assign w_rd_idx = i_read_addr >> OFF_BITS;
    assign w_wr_bad = ((i_write_addr & OFF_MASK) != '0) || (32'(w_wr_idx) >= NUM_REGS_U);
    assign w_rd_bad = ((i_read_addr & OFF_MASK) != '0) || (32'(w_rd_idx) >= NUM_REGS_U);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
        assign w_wr_sel[gi] = i_write_enable && !w_wr_bad && (32'(w_wr_idx) == 32'(gi));

        reg_file_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .MODE       (REG_MODE[2*gi +: 2]),
            .RESET_VAL  (RESET_VALUE[gi*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .i_clock    (i_clock),
            .i_aresetn  (i_aresetn),
            .i_wr_sel   (w_wr_sel[gi]),
            .i_wr_data  (i_write_data),
            .i_wr_strb  (i_write_strb),
            .i_hw_data  (i_hw_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .i_hw_set   (i_hw_set[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_q        (w_cell_q[gi])
        );

        assign o_reg_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_cell_q[gi];
        assign w_irq_bits[gi] = (REG_MODE[2*gi +: 2] == REG_MODE_W1C) ? |w_cell_q[gi] : 1'b0;
    end

    // Read mux over current register contents (pre-write value on a same-cycle write).
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_rd_idx) == 32'(i)) begin
                w_rd_word = w_cell_q[i];
            end
        end
    end

    // Registered read response; data holds between requests.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_read_err   <= 1'b0;
        end else if (i_read_enable) begin
            r_read_data  <= w_rd_bad ? '0 : w_rd_word;
            r_read_valid <= 1'b1;
            r_read_err   <= w_rd_bad;
        end else begin
            r_read_valid <= 1'b0;
            r_read_err   <= 1'b0;
        end
    end

    // One-cycle flag for a write that hit a bad address.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_write_err <= 1'b0;
        end else begin
            r_write_err <= i_write_enable && w_wr_bad;
        end
    end

    assign o_read_data  = r_read_data;
    assign o_read_valid = r_read_valid;
    assign o_read_err   = r_read_err;
    assign o_write_err  = r_write_err;
    assign o_irq        = |w_irq_bits;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param
module tb_reg_file_param;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam logic [2*NR-1:0]  MODES = 16'h0240;
    localparam logic [NR*DW-1:0] RV    = 256'h12345678 << 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } rd_exp_t;

    logic              i_clock = 1'b0;
    logic              i_aresetn = 1'b0;
    logic              i_write_enable = 1'b0;
    logic [AW-1:0]     i_write_addr = '0;
    logic [DW-1:0]     i_write_data = '0;
    logic [DW/8-1:0]   i_write_strb = '0;
    logic              i_read_enable = 1'b0;
    logic [AW-1:0]     i_read_addr = '0;
    logic [DW-1:0]     o_read_data;
    logic              o_read_valid;
    logic              o_read_err;
    logic              o_write_err;
    logic [NR*DW-1:0]  i_hw_data = 256'hCAFEF00D << 96;
    logic [NR*DW-1:0]  i_hw_set = '0;
    logic [NR*DW-1:0]  o_reg_data;
    logic              o_irq;

    int n_cmp = 0;
    int n_fail = 0;

    rd_exp_t q_rd[$];
    logic    q_we[$];
    logic    mon_rd_pend = 1'b0;
    logic    mon_wr_pend = 1'b0;

    reg_file_param #(
        .NUM_REGS    (NR),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .REG_MODE    (MODES),
        .RESET_VALUE (RV)
    ) dut (
        .i_clock        (i_clock),
        .i_aresetn      (i_aresetn),
        .i_write_enable (i_write_enable),
        .i_write_addr   (i_write_addr),
        .i_write_data   (i_write_data),
        .i_write_strb   (i_write_strb),
        .i_read_enable  (i_read_enable),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .o_read_valid   (o_read_valid),
        .o_read_err     (o_read_err),
        .o_write_err    (o_write_err),
        .i_hw_data      (i_hw_data),
        .i_hw_set       (i_hw_set),
        .o_reg_data     (o_reg_data),
        .o_irq          (o_irq)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Record which requests were issued at each edge (inputs are stable here).
    always @(posedge i_clock) begin
        mon_rd_pend = i_read_enable && i_aresetn;
        mon_wr_pend = i_write_enable && i_aresetn;
    end

    // Monitor: pop expectations whenever the DUT responds.
    always @(negedge i_clock) begin
        if (!i_aresetn) begin
            chk("reset_outputs", {o_read_valid, o_read_err, o_write_err}, '0);
            q_rd.delete();
            q_we.delete();
        end else begin
            if (mon_rd_pend) begin
                if (!o_read_valid) begin
                    chk("read_valid_missing", o_read_valid, 1);
                end else if (q_rd.size() == 0) begin
                    chk("read_queue_empty", 0, 1);
                end else begin
                    rd_exp_t e;
                    e = q_rd.pop_front();
                    chk("read_data", o_read_data, e.data);
                    chk("read_err", o_read_err, e.err);
                end
            end else if (o_read_valid) begin
                chk("read_valid_unexpected", o_read_valid, 0);
            end
            if (mon_wr_pend) begin
                if (q_we.size() == 0) begin
                    chk("write_queue_empty", 0, 1);
                end else begin
                    logic e;
                    e = q_we.pop_front();
                    chk("write_err", o_write_err, e);
                end
            end else if (o_write_err) begin
                chk("write_err_unexpected", o_write_err, 0);
            end
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, input logic bad);
        i_write_enable = 1'b1;
        i_write_addr   = a;
        i_write_data   = d;
        i_write_strb   = s;
        q_we.push_back(bad);
        @(posedge i_clock);
        #1;
        i_write_enable = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
        rd_exp_t e;
        e.data = d;
        e.err  = err;
        i_read_enable = 1'b1;
        i_read_addr   = a;
        q_rd.push_back(e);
        @(posedge i_clock);
        #1;
        i_read_enable = 1'b0;
    endtask

    function automatic logic [NR*DW-1:0] pack(input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                                              input logic [DW-1:0] r2, input logic [DW-1:0] r3,
                                              input logic [DW-1:0] r4);
        return {96'h0, r4, r3, r2, r1, r0};
    endfunction

    initial begin
        rd_exp_t e;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        chk("reset_regs", o_reg_data, RV);
        chk("reset_read_data", o_read_data, 0);
        chk("reset_irq", o_irq, 0);
        @(posedge i_clock);
        #1;
        i_aresetn = 1'b1;

        rd(8'h08, 32'h12345678, 1'b0);
        wr(8'h04, 32'hAABBCCDD, 4'b0101, 1'b0);
        rd(8'h04, 32'h00BB00DD, 1'b0);
        wr(8'h0C, 32'hFFFFFFFF, 4'hF, 1'b0);
        rd(8'h0C, 32'hCAFEF00D, 1'b0);

        i_hw_set[4*DW +: DW] = 32'h21;
        @(posedge i_clock);
        #1;
        i_hw_set = '0;
        @(negedge i_clock);
        chk("w1c_set_irq", o_irq, 1);
        chk("w1c_set_reg", o_reg_data[4*DW +: DW], 32'h21);
        wr(8'h10, 32'h01, 4'hF, 1'b0);
        @(negedge i_clock);
        chk("w1c_clr0_reg", o_reg_data[4*DW +: DW], 32'h20);
        chk("w1c_clr0_irq", o_irq, 1);
        i_hw_set[4*DW +: DW] = 32'h20;
        wr(8'h10, 32'h20, 4'hF, 1'b0);
        i_hw_set = '0;
        @(negedge i_clock);
        chk("w1c_set_wins", o_reg_data[4*DW +: DW], 32'h20);
        wr(8'h10, 32'h20, 4'hF, 1'b0);
        @(negedge i_clock);
        chk("w1c_clr5_reg", o_reg_data[4*DW +: DW], 32'h0);
        chk("w1c_clr5_irq", o_irq, 0);

        wr(8'h02, 32'hFFFFFFFF, 4'hF, 1'b1);
        wr(8'h20, 32'hFFFFFFFF, 4'hF, 1'b1);
        @(negedge i_clock);
        chk("bad_write_regs", o_reg_data, pack(32'h0, 32'h00BB00DD, 32'h12345678, 32'hCAFEF00D, 32'h0));
        rd(8'h21, 32'h0, 1'b1);
        rd(8'h20, 32'h0, 1'b1);
        rd(8'h1C, 32'h0, 1'b0);

        wr(8'h00, 32'h1, 4'hF, 1'b0);
        e.data = 32'h1;
        e.err  = 1'b0;
        q_rd.push_back(e);
        i_read_enable = 1'b1;
        i_read_addr   = 8'h00;
        wr(8'h00, 32'h2, 4'hF, 1'b0);
        i_read_enable = 1'b0;
        rd(8'h00, 32'h2, 1'b0);

        rd(8'h08, 32'h12345678, 1'b0);
        rd(8'h04, 32'h00BB00DD, 1'b0);
        rd(8'h0C, 32'hCAFEF00D, 1'b0);

        i_read_enable = 1'b1;
        i_read_addr   = 8'h08;
        @(posedge i_clock);
        #1;
        i_read_enable = 1'b0;
        i_aresetn     = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        i_aresetn = 1'b1;
        repeat (4) @(posedge i_clock);
        #1;
        @(negedge i_clock);
        chk("post_reset_regs", o_reg_data, pack(32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D, 32'h0));
        rd(8'h04, 32'h0, 1'b0);

        repeat (3) @(posedge i_clock);
        #1;
        chk("read_queue_drained", 32'(q_rd.size()), 0);
        chk("write_queue_drained", 32'(q_we.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
